// File: rtl/determ_addsub_acc.sv
// Multi-lane add/subtract-and-average unit for +/-1 deterministic bitstreams.
// Optional macro DETERM_ADDSUB_SAT_EN adds a per-lane saturation flag output.
module determ_addsub_acc #(
    parameter int BIT_WIDTH   = 16,
    parameter int INT_WIDTH   = 1,
    parameter int N_CH        = 2,
    parameter int WINDOW_LOG2 = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      en,
    input  logic                      clr,
    input  logic                      sub,
    input  logic [N_CH-1:0]           a,
    input  logic [N_CH-1:0]           b,
    output logic [N_CH*BIT_WIDTH-1:0] y,
    output logic                      y_valid
`ifdef DETERM_ADDSUB_SAT_EN
    ,
    output logic [N_CH-1:0]           sat
`endif
);

    localparam int FRAC  = BIT_WIDTH - INT_WIDTH - 1;
    localparam int ACC_W = WINDOW_LOG2 + 3;
    localparam int SH    = FRAC - WINDOW_LOG2;
    localparam int WIDE  = BIT_WIDTH + 4;

    localparam logic signed [ACC_W-1:0] PLUS2  = ACC_W'(2);
    localparam logic signed [ACC_W-1:0] MINUS2 = -PLUS2;
    localparam logic signed [WIDE-1:0]  YMAX   = {{(WIDE-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [WIDE-1:0]  YMIN   = {{(WIDE-BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};

    generate
        if (FRAC < WINDOW_LOG2) begin : g_bad_cfg
            $error("determ_addsub_acc: FRAC must be >= WINDOW_LOG2");
        end
    endgenerate

    // Subtraction negates B, which for a +/-1 bitstream is just inverting the bit.
    function automatic logic signed [ACC_W-1:0] contrib(input logic ai, input logic bi, input logic sm);
        logic bt;
        bt = sm ? ~bi : bi;
        if (ai && bt)   return PLUS2;
        if (!ai && !bt) return MINUS2;
        return '0;
    endfunction

    function automatic logic signed [WIDE-1:0] scale(input logic signed [ACC_W-1:0] v);
        return WIDE'(v) <<< SH;
    endfunction

    function automatic logic [BIT_WIDTH-1:0] sat_val(input logic signed [ACC_W-1:0] v);
        logic signed [WIDE-1:0] w;
        w = scale(v);
        if (w > YMAX) return YMAX[BIT_WIDTH-1:0];
        if (w < YMIN) return YMIN[BIT_WIDTH-1:0];
        return w[BIT_WIDTH-1:0];
    endfunction

`ifdef DETERM_ADDSUB_SAT_EN
    function automatic logic is_sat(input logic signed [ACC_W-1:0] v);
        logic signed [WIDE-1:0] w;
        w = scale(v);
        return (w > YMAX) || (w < YMIN);
    endfunction

    logic [N_CH-1:0] sat_p1;
`endif

    logic [WINDOW_LOG2-1:0]    cnt_p0;
    logic signed [ACC_W-1:0]   acc_p0 [N_CH];
    logic signed [ACC_W-1:0]   sum_c  [N_CH];
    logic                      win_end;
    logic [N_CH*BIT_WIDTH-1:0] y_p1;
    logic                      vld_p1;

    // Stage 0: per-lane running sum including the current sample
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            sum_c[i] = acc_p0[i] + contrib(a[i], b[i], sub);
        end
    end

    assign win_end = en && !clr && (cnt_p0 == '1);

    // Stage 1: window accumulation and registered lane means
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_p0 <= '0;
            vld_p1 <= 1'b0;
            y_p1   <= '0;
            for (int i = 0; i < N_CH; i++) acc_p0[i] <= '0;
`ifdef DETERM_ADDSUB_SAT_EN
            sat_p1 <= '0;
`endif
        end else begin
            vld_p1 <= win_end;
            if (clr) begin
                cnt_p0 <= '0;
                for (int i = 0; i < N_CH; i++) acc_p0[i] <= '0;
            end else if (en) begin
                cnt_p0 <= cnt_p0 + 1'b1;
                for (int i = 0; i < N_CH; i++) acc_p0[i] <= win_end ? '0 : sum_c[i];
            end
            if (win_end) begin
                for (int i = 0; i < N_CH; i++) begin
                    y_p1[i*BIT_WIDTH +: BIT_WIDTH] <= sat_val(sum_c[i]);
`ifdef DETERM_ADDSUB_SAT_EN
                    sat_p1[i] <= is_sat(sum_c[i]);
`endif
                end
            end
        end
    end

    assign y       = y_p1;
    assign y_valid = vld_p1;
`ifdef DETERM_ADDSUB_SAT_EN
    assign sat     = sat_p1;
`endif

endmodule

// File: tb/tb_determ_addsub_acc.sv
// Randomized and directed self-checking bench for determ_addsub_acc.
module tb_determ_addsub_acc;

    localparam int BW   = 16;
    localparam int IW   = 1;
    localparam int NC   = 2;
    localparam int WL   = 4;
    localparam int FRAC = BW - IW - 1;
    localparam int WIN  = 1 << WL;
    localparam int YMAXI = (1 << (BW - 1)) - 1;
    localparam int YMINI = -(1 << (BW - 1));

    logic            CLK;
    logic            RST;
    logic            en;
    logic            clr;
    logic            sub;
    logic [NC-1:0]   a;
    logic [NC-1:0]   b;
    logic [NC*BW-1:0] y;
    logic            y_valid;
`ifdef DETERM_ADDSUB_SAT_EN
    logic [NC-1:0]   sat;
`endif

    determ_addsub_acc #(
        .BIT_WIDTH(BW), .INT_WIDTH(IW), .N_CH(NC), .WINDOW_LOG2(WL)
    ) dut (
        .CLK(CLK), .RST(RST), .en(en), .clr(clr), .sub(sub),
        .a(a), .b(b), .y(y), .y_valid(y_valid)
`ifdef DETERM_ADDSUB_SAT_EN
        , .sat(sat)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;
    bit started = 1'b0;

    // Reference model: window count, per-lane running sums, expected outputs
    int            mcnt;
    int            msum  [NC];
    int            exp_y [NC];
    logic [NC-1:0] exp_sat;
    logic          exp_valid;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        mcnt = 0;
        exp_valid = 1'b0;
        exp_sat = '0;
        for (int i = 0; i < NC; i++) begin
            msum[i] = 0;
            exp_y[i] = 0;
        end
    endtask

    task automatic model_update(input logic e, input logic c, input logic s,
                                input logic [NC-1:0] aa, input logic [NC-1:0] bb);
        int va, vb, m;
        exp_valid = 1'b0;
        if (c) begin
            mcnt = 0;
            for (int i = 0; i < NC; i++) msum[i] = 0;
        end else if (e) begin
            for (int i = 0; i < NC; i++) begin
                va = aa[i] ? 1 : -1;
                vb = bb[i] ? 1 : -1;
                msum[i] += s ? (va - vb) : (va + vb);
            end
            mcnt++;
            if (mcnt == WIN) begin
                for (int i = 0; i < NC; i++) begin
                    m = msum[i] * (1 << (FRAC - WL));
                    exp_sat[i] = (m > YMAXI) || (m < YMINI);
                    if (m > YMAXI) m = YMAXI;
                    if (m < YMINI) m = YMINI;
                    exp_y[i] = m;
                    msum[i] = 0;
                end
                exp_valid = 1'b1;
                mcnt = 0;
            end
        end
    endtask

    task automatic step(input logic e, input logic c, input logic s,
                        input logic [NC-1:0] aa, input logic [NC-1:0] bb);
        en = e; clr = c; sub = s; a = aa; b = bb;
        @(posedge CLK);
        model_update(e, c, s, aa, bb);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        en = 1'b0; clr = 1'b0; sub = 1'b0; a = '0; b = '0;
        #2 RST = 1'b1;
        model_reset();
        #1;
        chk("rst_y", 32'(y), 32'h0);
        chk("rst_y_valid", 32'(y_valid), 32'h0);
        @(negedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        if (started) begin
            chk("y_valid", 32'(y_valid), 32'(exp_valid));
            for (int i = 0; i < NC; i++)
                chk($sformatf("y_lane%0d", i), 32'(y[i*BW +: BW]), 32'(exp_y[i][BW-1:0]));
`ifdef DETERM_ADDSUB_SAT_EN
            chk("sat", 32'(sat), 32'(exp_sat));
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int nv;
        logic [NC-1:0] ra, rb;
        RST = 1'b0; en = 1'b0; clr = 1'b0; sub = 1'b0; a = '0; b = '0;
        model_reset();
        do_reset();
        started = 1'b1;

        // lane0 +1 - (-1) = +2 saturates; lane1 equal operands give 0
        for (int i = 0; i < WIN; i++) step(1, 0, 1, 2'b11, 2'b10);
        chk("s1_valid", 32'(y_valid), 32'h1);
        chk("s1_y", 32'(y), 32'h0000_7fff);
`ifdef DETERM_ADDSUB_SAT_EN
        chk("s1_sat", 32'(sat), 32'h1);
`endif

        // -2.0 then +2.0 back to back
        for (int i = 0; i < WIN; i++) step(1, 0, 0, 2'b00, 2'b00);
        chk("s2_y_neg", 32'(y), 32'h8000_8000);
        for (int i = 0; i < WIN; i++) step(1, 0, 0, 2'b11, 2'b11);
        chk("s2_y_pos", 32'(y), 32'h7fff_7fff);

        // clr on the window-end sample: no strobe, y kept
        for (int i = 0; i < WIN - 1; i++) step(1, 0, 0, 2'b00, 2'b00);
        step(1, 1, 0, 2'b00, 2'b00);
        chk("s7_valid", 32'(y_valid), 32'h0);
        chk("s7_y", 32'(y), 32'h7fff_7fff);

        // alternating operands give +1.0
        for (int i = 0; i < WIN; i++) step(1, 0, 1, {1'b1, 1'(i % 2 == 0)}, 2'b10);
        chk("s3_y_lane0", 32'(y), 32'h0000_4000);
        for (int i = 0; i < WIN; i++) step(1, 0, 0, 2'b11, {1'(i % 2 == 0), 1'b1});
        chk("s3_y_lane1", 32'(y), 32'h4000_7fff);

        // en every other cycle
        nv = 0;
        for (int i = 0; i < 2 * WIN; i++) begin
            step(1'(i % 2 == 0), 0, 0, 2'b01, 2'b01);
            if (y_valid) nv++;
            if (i == 2 * WIN - 2) chk("s4_valid_pos", 32'(y_valid), 32'h1);
        end
        chk("s4_valid_count", 32'(nv), 32'h1);
        chk("s4_y", 32'(y), 32'h8000_7fff);

        // clr after 10 samples, then a window of a==b with sub=1
        nv = 0;
        for (int i = 0; i < 10; i++) step(1, 0, 0, 2'b11, 2'b11);
        step(1, 1, 0, 2'b11, 2'b11);
        for (int i = 0; i < WIN; i++) begin
            ra = NC'($urandom);
            step(1, 0, 1, ra, ra);
            if (y_valid) nv++;
        end
        chk("s5_valid_count", 32'(nv), 32'h1);
        chk("s5_y", 32'(y), 32'h0);

        // reset mid-window, then a fresh window of 16
        for (int i = 0; i < 7; i++) step(1, 0, 1, 2'b11, 2'b00);
        do_reset();
        nv = 0;
        for (int i = 0; i < WIN - 1; i++) begin
            step(1, 0, 1, 2'b11, 2'b00);
            if (y_valid) nv++;
        end
        chk("s6_no_early_valid", 32'(nv), 32'h0);
        step(1, 0, 1, 2'b11, 2'b00);
        chk("s6_valid", 32'(y_valid), 32'h1);
        chk("s6_y", 32'(y), 32'h7fff_7fff);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            ra = NC'($urandom);
            rb = NC'($urandom);
            if (i % 64 < 20) rb = ~ra;
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0),
                 1'($urandom), ra, rb);
        end

        started = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/determ_addsub_acc.md
Name: determ_addsub_acc

Overview:
- Multi-lane add/subtract-and-average unit for deterministic bitstreams, where bit 1 = +1.0 and bit 0 = -1.0.
- Each lane combines operand bits a and b every accepted cycle into a ±1 sum or difference, then accumulates over a window of 2^WINDOW_LOG2 accepted samples.
- At window end each lane emits the window mean as a signed fixed-point word with a one-cycle valid strobe.
- Sits between bitstream arithmetic and fixed-point consumers, replacing per-cycle combinational subtract units where a decoded value is needed.

Parameters:
- BIT_WIDTH, 16, output word width per lane; sign + integer + fraction bits.
- INT_WIDTH, 1, integer bits excluding sign; FRAC = BIT_WIDTH - INT_WIDTH - 1; 1.0 = 1 << FRAC.
- N_CH, 2, number of independent lanes.
- WINDOW_LOG2, 4, window length = 2^WINDOW_LOG2 accepted samples. Must satisfy FRAC >= WINDOW_LOG2; elaboration error otherwise.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- en  input  1  sample accept; one sample per lane consumed per cycle with en=1.
- clr  input  1  synchronous window restart.
- sub  input  1  mode: 1 = a-b, 0 = a+b; sampled with each accepted sample, applies to all lanes.
- a  input  N_CH  operand bitstreams, bit i = lane i.
- b  input  N_CH  operand bitstreams, bit i = lane i.
- y  output  N_CH*BIT_WIDTH  signed lane means; lane i at bits [i*BIT_WIDTH +: BIT_WIDTH]; registered.
- y_valid  output  1  one-cycle strobe; y updated.

Behaviour:
- Reset (async, RST=1): y=0, y_valid=0, sample counter=0, all lane accumulators=0.
- Per accepted sample, per lane, ±1 values A and B:
  - Contribution s = A+B (sub=0) or A-B (sub=1).
  - s is in {-2, 0, +2}, held as a signed integer.
- Accumulator: signed, WINDOW_LOG2+3 bits, so it holds ±2^(WINDOW_LOG2+1) exactly.
- Counter: WINDOW_LOG2 bits, increments per accepted sample and wraps to 0 at window end.
- Window end: the accepted sample that brings the count to 2^WINDOW_LOG2.
  - On that edge, per lane, y = (acc + s) << (FRAC - WINDOW_LOG2). This is the exact mean, with no rounding.
  - On the same edge, the accumulator clears to 0 and y_valid is set for exactly the following cycle.
- Saturation: if the mean exceeds the most positive code (e.g. +2.0 with INT_WIDTH=1), y takes the max positive value 0x7FFF for 16 bits. -2.0 is representable (0x8000) and does not saturate.
- Latency: y and y_valid appear one cycle after the last sample of the window.
- Windows run back to back with no gap. A sample accepted while y_valid=1 counts toward the next window.
- y holds its value between windows; y_valid=0 otherwise.
- en=0: no state change except y_valid clearing.
- clr=1: counter and accumulators go to 0 on the next edge; y is unchanged.
  - clr has priority over en: a sample in the same cycle is discarded.
  - clr coinciding with a window-end sample: the window is discarded, no y_valid, y unchanged.
- RST mid-window: partial window lost; all outputs return to reset values immediately.
- Lanes are fully independent; they share only the counter and the sub mode.

Optional Feature:
- Macro: DETERM_ADDSUB_SAT_EN.
- Defined: adds output port sat, N_CH bits, registered with y. sat[i]=1 when lane i saturated in the latest window; it holds until the next window end and resets to 0.
- Undefined: port absent; saturation of y still performed identically.

Test Plan:
All cases use defaults (FRAC=14, 1.0 = 0x4000, window = 16).
- Lane0 a=1, b=0, sub=1, en=1 for 16 cycles -> one cycle later y_valid=1, lane0 y=0x7FFF (saturated +2.0), sat[0]=1 if enabled. Lane1 a=b=1 -> 0x0000.
- a=0, b=0, sub=0 for 16 samples -> y=0x8000 (-2.0), sat=0. Then a=1, b=1, sub=0 for the next 16 with no gap -> next y=0x7FFF.
- Lane0 a alternating 1,0 with b=0, sub=1 -> y=0x4000 (+1.0). Lane1 a=1, b alternating 1,0, sub=0 -> y=0x4000.
- en high every other cycle for 32 cycles -> exactly one y_valid, one cycle after the 16th accepted sample; y unchanged while en=0.
- Assert clr after 10 samples of all-ones, then 16 samples of a=b, sub=1 -> only the post-clr window reported (y=0x0000).
- clr asserted on the 16th sample -> no y_valid, y retains its previous value.
- RST pulsed mid-window -> y=0, y_valid=0 immediately; next y_valid only after 16 fresh samples.
